// File: rtl/dot_product_accumulator.sv
// Sums K unsigned product words into one AW-bit dot product with overflow reporting.
// Optional clamp-on-overflow arithmetic enabled by DOT_PRODUCT_ACCUMULATOR_SATURATE_EN.
module dot_product_accumulator #(
    parameter int unsigned PW = 64,
    parameter int unsigned K  = 4,
    parameter int unsigned AW = 66
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [PW-1:0] prod_in,
    input  logic          prod_valid,
    output logic [AW-1:0] acc_out,
    output logic          acc_done,
    output logic          busy,
    output logic [7:0]    term_cnt,
    output logic          ovf
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam int unsigned SW     = AW + 1;
    localparam logic [7:0]  LAST   = 8'(K - 1);
    localparam bit          SINGLE = (K == 1);

    logic [0:0]    state, state_d;
    logic [AW-1:0] psum, psum_d;
    logic [7:0]    cnt_d;
    logic          povf, povf_d;
    logic [AW-1:0] acc_out_d;
    logic          acc_done_d;
    logic          ovf_d;

    logic [SW-1:0] sum;
    logic          next_ovf;
    logic [AW-1:0] next_psum;

    // Running sum with carry; povf remembers any earlier carry in this dot product
    always_comb begin
        sum      = {1'b0, psum} + SW'(prod_in);
        next_ovf = povf | sum[AW];
`ifdef DOT_PRODUCT_ACCUMULATOR_SATURATE_EN
        next_psum = next_ovf ? {AW{1'b1}} : sum[AW-1:0];
`else
        next_psum = sum[AW-1:0];
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state;
        psum_d     = psum;
        cnt_d      = term_cnt;
        povf_d     = povf;
        acc_out_d  = acc_out;
        ovf_d      = ovf;
        acc_done_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            psum_d  = '0;
            cnt_d   = 8'd0;
            povf_d  = 1'b0;
        end else if (prod_valid) begin
            if (state == IDLE) begin
                if (SINGLE) begin
                    acc_out_d  = AW'(prod_in);
                    ovf_d      = 1'b0;
                    acc_done_d = 1'b1;
                end else begin
                    psum_d  = AW'(prod_in);
                    cnt_d   = 8'd1;
                    povf_d  = 1'b0;
                    state_d = ACCUM;
                end
            end else if (term_cnt == LAST) begin
                acc_out_d  = next_psum;
                ovf_d      = next_ovf;
                acc_done_d = 1'b1;
                psum_d     = '0;
                cnt_d      = 8'd0;
                povf_d     = 1'b0;
                state_d    = IDLE;
            end else begin
                psum_d = next_psum;
                povf_d = next_ovf;
                cnt_d  = 8'(term_cnt + 8'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            psum     <= '0;
            term_cnt <= 8'd0;
            povf     <= 1'b0;
            acc_out  <= '0;
            ovf      <= 1'b0;
            acc_done <= 1'b0;
        end else begin
            state    <= state_d;
            psum     <= psum_d;
            term_cnt <= cnt_d;
            povf     <= povf_d;
            acc_out  <= acc_out_d;
            ovf      <= ovf_d;
            acc_done <= acc_done_d;
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: default instance plus an AW=65 overflow instance.
module tb_dot_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, prod_valid;
    logic [63:0] prod_in;
    logic [65:0] acc_out;
    logic        acc_done, busy, ovf;
    logic [7:0]  term_cnt;

    logic        b_reset, b_clear, b_valid;
    logic [63:0] b_prod;
    logic [64:0] b_acc_out;
    logic        b_done, b_busy, b_ovf;
    logic [7:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    dot_product_accumulator dut (
        .clk(clk), .reset(reset), .clear(clear), .prod_in(prod_in),
        .prod_valid(prod_valid), .acc_out(acc_out), .acc_done(acc_done),
        .busy(busy), .term_cnt(term_cnt), .ovf(ovf)
    );

    dot_product_accumulator #(.PW(64), .K(4), .AW(65)) dut_big (
        .clk(clk), .reset(b_reset), .clear(b_clear), .prod_in(b_prod),
        .prod_valid(b_valid), .acc_out(b_acc_out), .acc_done(b_done),
        .busy(b_busy), .term_cnt(b_cnt), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] v);
        prod_in    = v;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        tick();
    endtask

    logic [64:0] big_exp;

    initial begin
        reset = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_in = '0;
        b_reset = 1'b1; b_clear = 1'b0; b_valid = 1'b0; b_prod = '0;
        tick(); tick();
        check("rst_acc_out", 128'(acc_out), 128'd0);
        check("rst_done", 128'(acc_done), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_cnt", 128'(term_cnt), 128'd0);
        check("rst_ovf", 128'(ovf), 128'd0);
        reset = 1'b0; b_reset = 1'b0;
        tick();

        // 1,2,3,4 consecutive
        prod_valid = 1'b1;
        prod_in = 64'd1; tick();
        check("seq_busy1", 128'(busy), 128'd1);
        check("seq_cnt1", 128'(term_cnt), 128'd1);
        prod_in = 64'd2; tick();
        prod_in = 64'd3; tick();
        check("seq_done_early", 128'(acc_done), 128'd0);
        check("seq_cnt3", 128'(term_cnt), 128'd3);
        prod_in = 64'd4; tick();
        prod_valid = 1'b0;
        check("seq_done", 128'(acc_done), 128'd1);
        check("seq_acc", 128'(acc_out), 128'd10);
        check("seq_ovf", 128'(ovf), 128'd0);
        check("seq_busy_end", 128'(busy), 128'd0);
        check("seq_cnt_end", 128'(term_cnt), 128'd0);
        idle();
        check("seq_done_pulse", 128'(acc_done), 128'd0);
        check("seq_acc_hold", 128'(acc_out), 128'd10);

        // 5,0,7,9 with 3 idle cycles between
        push(64'd5);
        for (int g = 0; g < 3; g++) begin
            idle();
            check("gap_busy", 128'(busy), 128'd1);
            check("gap_cnt", 128'(term_cnt), 128'd1);
        end
        push(64'd0);
        for (int g = 0; g < 3; g++) idle();
        check("gap_cnt2", 128'(term_cnt), 128'd2);
        push(64'd7);
        for (int g = 0; g < 3; g++) idle();
        check("gap_busy3", 128'(busy), 128'd1);
        check("gap_acc_hold", 128'(acc_out), 128'd10);
        push(64'd9);
        check("gap_done", 128'(acc_done), 128'd1);
        check("gap_acc", 128'(acc_out), 128'd21);
        check("gap_busy_end", 128'(busy), 128'd0);
        idle();

        // Back-to-back 1..8
        prod_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            prod_in = 64'(i);
            tick();
            if (i == 4) begin
                check("b2b_done1", 128'(acc_done), 128'd1);
                check("b2b_acc1", 128'(acc_out), 128'd10);
            end
            if (i == 5) begin
                check("b2b_nodone", 128'(acc_done), 128'd0);
                check("b2b_cnt5", 128'(term_cnt), 128'd1);
                check("b2b_busy5", 128'(busy), 128'd1);
            end
        end
        prod_valid = 1'b0;
        check("b2b_done2", 128'(acc_done), 128'd1);
        check("b2b_acc2", 128'(acc_out), 128'd26);
        idle();

        // Clear wins over a simultaneous valid
        push(64'd100);
        push(64'd200);
        clear = 1'b1; prod_in = 64'd300; prod_valid = 1'b1;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        check("clr_busy", 128'(busy), 128'd0);
        check("clr_cnt", 128'(term_cnt), 128'd0);
        check("clr_done", 128'(acc_done), 128'd0);
        check("clr_acc_hold", 128'(acc_out), 128'd26);
        push(64'd1); push(64'd2); push(64'd3); push(64'd4);
        check("clr_done2", 128'(acc_done), 128'd1);
        check("clr_acc", 128'(acc_out), 128'd10);
        idle();

        // Reset mid-operation
        push(64'd100);
        push(64'd200);
        reset = 1'b1; prod_in = 64'd300; prod_valid = 1'b1; clear = 1'b1;
        tick();
        reset = 1'b0; prod_valid = 1'b0; clear = 1'b0;
        check("mrst_done", 128'(acc_done), 128'd0);
        check("mrst_acc", 128'(acc_out), 128'd0);
        check("mrst_busy", 128'(busy), 128'd0);
        check("mrst_cnt", 128'(term_cnt), 128'd0);
        check("mrst_ovf", 128'(ovf), 128'd0);
        idle();
        check("mrst_done_after", 128'(acc_done), 128'd0);

        // AW=65 overflow: four products of 2^64-1
`ifdef DOT_PRODUCT_ACCUMULATOR_SATURATE_EN
        big_exp = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
`else
        big_exp = {1'b1, 64'hFFFF_FFFF_FFFF_FFFC};
`endif
        b_valid = 1'b1;
        b_prod  = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) tick();
        b_valid = 1'b0;
        check("big_done", 128'(b_done), 128'd1);
        check("big_acc", 128'(b_acc_out), 128'(big_exp));
        check("big_ovf", 128'(b_ovf), 128'd1);
        tick();
        check("big_ovf_hold", 128'(b_ovf), 128'd1);
        check("big_acc_hold", 128'(b_acc_out), 128'(big_exp));

        // ovf clears on the next non-overflowing result
        b_valid = 1'b1;
        b_prod  = 64'd1;
        for (int i = 0; i < 4; i++) tick();
        b_valid = 1'b0;
        check("big_acc_small", 128'(b_acc_out), 128'd4);
        check("big_ovf_clr", 128'(b_ovf), 128'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
